// File: rtl/jk_seq_driver.sv
// jk_seq_driver: J/K sequencer for an external modulo-MODULUS up/down JK bank; `GRAY_SEQ_EN selects a Gray-coded sequence
module jk_seq_driver #(
  parameter int WIDTH = 4,
  parameter int MODULUS = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] q_fb,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  output logic [WIDTH-1:0] exp_q,
  output logic             tc,
  output logic             err
);
  typedef enum logic [1:0] {IDLE, RUN, ERR} state_t;
  localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);
  state_t state;
  logic [WIDTH-1:0] cur, lidx, ltgt, nidx, tgt;
  logic step, mismatch, drive, upd;
`ifdef GRAY_SEQ_EN
  logic [WIDTH-1:0] idx;
  function automatic logic [WIDTH-1:0] g2b(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction
  assign cur  = idx;
  assign lidx = g2b(load_val);
  assign tgt  = nidx ^ (nidx >> 1);
`else
  assign cur  = exp_q;
  assign lidx = load_val;
  assign tgt  = nidx;
`endif
  // next index selection, mismatch detection and JK excitation toward the target
  always_comb begin
    step     = state == RUN && en && !load;
    mismatch = state == RUN && !load && q_fb != exp_q;
    drive    = !rst && (load || state == RUN);
    upd      = load || (step && !mismatch);
    ltgt     = int'(lidx) >= MODULUS ? '0 : lidx;
    nidx     = load ? ltgt
             : step ? (up ? (cur == LAST ? '0 : cur + 1'b1) : (cur == '0 ? LAST : cur - 1'b1))
             : cur;
    j        = drive ? tgt & ~q_fb : '0;
    k        = drive ? ~tgt & q_fb : '0;
    tc       = step && (up ? cur == LAST : cur == '0);
  end
  // control FSM with the registered bank model and sticky error flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      exp_q <= '0;
      err   <= 1'b0;
    end else if (load) begin
      state <= RUN;
      exp_q <= tgt;
      err   <= 1'b0;
    end else if (mismatch) begin
      state <= ERR;
      err   <= 1'b1;
    end else if (step) begin
      exp_q <= tgt;
    end
  end
`ifdef GRAY_SEQ_EN
  // binary index behind the Gray-coded model, advanced alongside exp_q
  always_ff @(posedge clk or posedge rst) begin
    if (rst) idx <= '0;
    else if (upd) idx <= nidx;
  end
`endif
endmodule

// File: tb/tb_jk_seq_driver.sv
// tb_jk_seq_driver: directed plus random checks of jk_seq_driver against a JK bank plant and a modular-count model
module tb_jk_seq_driver;
  localparam int W = 4;
`ifdef GRAY_SEQ_EN
  localparam int MOD = 16;
`else
  localparam int MOD = 10;
`endif
  logic clk = 0, rst = 1, en = 0, up = 0, load = 0;
  logic [W-1:0] load_val = '0, q_fb = '0, j, k, exp_q;
  logic tc, err;
  int ntests = 0, nfail = 0;
  int mstate = 0, n = 0, merr = 0;
  int gseq [4] = '{1, 3, 2, 6};

  jk_seq_driver #(.WIDTH(W), .MODULUS(MOD)) dut (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
    .q_fb(q_fb), .j(j), .k(k), .exp_q(exp_q), .tc(tc), .err(err)
  );

  always #5 clk = ~clk;

  function automatic int enc(int v);
`ifdef GRAY_SEQ_EN
    return v ^ (v >> 1);
`else
    return v;
`endif
  endfunction

  function automatic int dec(int v);
    int b = 0;
`ifdef GRAY_SEQ_EN
    for (int s = 0; s < W; s++) b ^= v >> s;
`else
    b = v;
`endif
    return b;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    ntests++;
    assert (obs === expv) else begin
      nfail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic step(input logic e, input logic u, input logic l, input logic [W-1:0] lv);
    int t, me;
    logic [W-1:0] tv, jj, kk;
    logic act, mm;
    @(negedge clk);
    en = e; up = u; load = l; load_val = lv;
    me = enc(n);
    t = l ? (dec(int'(lv)) >= MOD ? 0 : dec(int'(lv)))
      : (mstate == 1 && e) ? (u ? (n + 1) % MOD : (n + MOD - 1) % MOD) : n;
    tv = W'(enc(t));
    act = l || mstate == 1;
    #1;
    chk("j", j, act ? tv & ~q_fb : '0);
    chk("k", k, act ? ~tv & q_fb : '0);
    chk("tc", tc, mstate == 1 && e && !l && (u ? n == MOD - 1 : n == 0));
    chk("exp_q_pre", exp_q, me);
`ifdef GRAY_SEQ_EN
    if (mstate == 1 && e && !l && int'(q_fb) == me) chk("one_bit", $countones(j | k), 1);
`endif
    mm = mstate == 1 && !l && int'(q_fb) != me;
    jj = j; kk = k;
    @(posedge clk);
    #1;
    q_fb = (jj & ~q_fb) | (~kk & q_fb);
    if (l) begin mstate = 1; merr = 0; n = t; end
    else if (mm) begin mstate = 2; merr = 1; end
    else if (mstate == 1 && e) n = t;
    chk("exp_q", exp_q, enc(n));
    chk("err", err, merr);
    if (mstate == 1) chk("bank", q_fb, enc(n));
  endtask

  initial begin
    q_fb = W'($urandom);
    load = 1; load_val = 3;
    #1;
    chk("rst_j", j, 0);
    chk("rst_k", k, 0);
    chk("rst_exp", exp_q, 0);
    chk("rst_err", err, 0);
    chk("rst_tc", tc, 0);
    @(negedge clk);
    rst = 0; load = 0;
    step(1, 1, 0, 0);
    step(0, 0, 1, 3);
    step(0, 0, 1, 8);
    repeat (3) step(1, 1, 0, 0);
    step(0, 0, 1, 1);
    repeat (3) step(1, 0, 0, 0);
    repeat (5) step(0, 1, 0, 0);
    step(0, 0, 1, 12);
    step(0, 0, 1, 5);
    q_fb = 7;
    step(1, 1, 0, 0);
    repeat (2) step(1, 1, 0, 0);
    step(1, 1, 1, 2);
    step(1, 1, 0, 0);
`ifdef GRAY_SEQ_EN
    step(0, 1, 1, 0);
    for (int i = 0; i < 4; i++) begin
      step(1, 1, 0, 0);
      chk("gray_seq", exp_q, gseq[i]);
    end
`endif
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(39) == 0) q_fb = q_fb ^ W'($urandom_range(1, (1 << W) - 1));
      step(1'($urandom), 1'($urandom), $urandom_range(7) == 0, W'($urandom));
    end
    step(0, 1, 1, 4);
    step(1, 1, 0, 0);
    @(negedge clk);
    en = 1; up = 1; load = 0;
    #2;
    rst = 1;
    #1;
    chk("arst_j", j, 0);
    chk("arst_k", k, 0);
    chk("arst_exp", exp_q, 0);
    chk("arst_err", err, 0);
    @(negedge clk);
    rst = 0;
    mstate = 0; n = 0; merr = 0;
    step(1, 1, 0, 0);
    step(0, 1, 1, 6);
    repeat (4) step(1, 0, 0, 0);
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule

// File: doc/jk_seq_driver.md
Name: jk_seq_driver

Overview:
- Drives the J/K inputs of an external WIDTH-bit bank of JK flip-flops so that the bank steps through a modulo-MODULUS up/down count sequence.
- J/K are derived from the JK excitation table, using the bank's fed-back Q and the required next state.
- The block keeps its own model of the bank state and flags any divergence between model and feedback.
- It sits beside the JK register bank, on the same clock, as its sequencing front end.

Parameters:
WIDTH, 4, bit width of the driven JK bank.
MODULUS, 10, sequence length; 2 <= MODULUS <= 2^WIDTH.

Ports:
clk  input  1  system clock, rising edge; the JK bank uses the same clock.
rst  input  1  asynchronous, active-high reset.
en  input  1  advance enable; when 0 the bank is held.
up  input  1  direction: 1 = count up, 0 = count down.
load  input  1  synchronous load request.
load_val  input  WIDTH  state to load.
q_fb  input  WIDTH  Q outputs fed back from the JK bank.
j  output  WIDTH  J drive to the bank.
k  output  WIDTH  K drive to the bank.
exp_q  output  WIDTH  expected bank state (internal model).
tc  output  1  terminal count; next step wraps.
err  output  1  sticky mismatch flag.

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high.
- Reset values: state=IDLE, exp_q=0, err=0. j=0 and k=0 while rst is high and while in IDLE.
- States:
  - IDLE: outputs held at 0. load -> RUN. Otherwise stay.
  - RUN: normal sequencing. Mismatch -> ERR, unless load is high that cycle.
  - ERR: j=k=0 (bank holds). Only load or rst exits; load -> RUN.
- Target selection, combinational each cycle (tgt):
  - load=1: tgt=load_val. If load_val >= MODULUS, tgt=0.
  - RUN & en & up: tgt = exp_q==MODULUS-1 ? 0 : exp_q+1.
  - RUN & en & !up: tgt = exp_q==0 ? MODULUS-1 : exp_q-1.
  - Otherwise: tgt=exp_q (hold).
- Excitation, combinational, don't-cares resolved to 0: j = tgt & ~q_fb; k = ~tgt & q_fb. A bit already at its target gets j=k=0. Outputs are forced to 0 in IDLE and ERR unless load=1.
- On each clk edge:
  - exp_q <= tgt, in any state, whenever load=1 or (RUN & en).
  - The bank reaches tgt on the same edge: zero latency from j/k valid to bank update.
- Mismatch check: in RUN with load=0, if q_fb != exp_q, then on the next edge err<=1, state<=ERR, and exp_q is not updated.
- Load behaviour: load clears err on the same edge. Load has priority over en and over mismatch detection.
- tc: high when state=RUN, en=1, load=0, and the next step wraps (exp_q==MODULUS-1 with up=1, or exp_q==0 with up=0).
- Arithmetic: WIDTH-bit unsigned; no value >= MODULUS ever appears on exp_q.
- Reset mid-operation: outputs clear immediately. The external bank is not reset by this block; the first load resynchronises it.

Optional Feature:
GRAY_SEQ_EN
- Defined:
  - An internal binary index idx (reset 0) runs the modulo/wrap rules above.
  - tgt and exp_q are the Gray code of the index: g = i ^ (i>>1). load_val is interpreted as a Gray value and converted to binary for idx.
  - In normal stepping only one J or K bit is active per step. Cyclic single-bit wrap holds only for MODULUS = 2^WIDTH.
- Undefined: plain binary sequence; no idx register.

Test Plan:
- Reset then load: rst pulse; bank model q_fb=x; load=1, load_val=3 -> j/k drive the bank to 3 on that edge; exp_q=3, state RUN, err=0.
- Up count with wrap: from 8, en=1, up=1, q_fb tracks -> sequence 9,0,1; tc=1 only in the exp_q=9 cycle. At q_fb=9 going to 0: j=0000, k=1001.
- Down count with wrap: from 1, up=0 -> 0,9,8; tc=1 when exp_q=0. At q_fb=0 going to 9: j=1001, k=0000.
- Hold and out-of-range load: en=0 -> j=k=0, exp_q constant for 5 cycles. load_val=12 -> exp_q=0.
- Mismatch: in RUN with exp_q=5, force q_fb=7 -> next edge err=1, ERR, j=k=0. exp_q stays 5 until load_val=2 -> err=0, RUN, exp_q=2.
- GRAY_SEQ_EN, MODULUS=16: from load 0, up, 4 steps -> exp_q 0001,0011,0010,0110; exactly one j or k bit high per step. Async rst mid-step clears outputs without waiting for clk.
